// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART receiver that streams bytes into instruction memory while Load is high.
// Flags framing errors, reports a byte count, and asserts Done once MEM_DEPTH words are written.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int MEM_DEPTH    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RX,
    input  logic              Load,
    output logic              Wr_en,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [DATA_W-1:0] Wr_data,
    output logic              FE,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   Byte_count
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_q, state_d;
    logic rx_s1_q, rx_s2_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic load_q;
    logic wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic fe_q, fe_d;
    logic done_q, done_d;
    logic [ADDR_W:0] count_q, count_d, count_base;
    logic stop_ok, stop_bad, rise, wr;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                state_d = rx_s2_q ? IDLE : START;
            end
            START: if (timer_q == HALF) begin
                timer_d = '0;
                idx_d   = '0;
                state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (timer_q == FULL) begin
                timer_d = '0;
                shift_d = {rx_s2_q, shift_q[DATA_W-1:1]};
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == LAST) ? STOP : DATA;
            end
            STOP: if (timer_q == FULL) begin
                stop_ok  = rx_s2_q;
                stop_bad = !rx_s2_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load rising edge clears the session first, so a coinciding byte lands at address 0.
    always_comb begin
        rise       = Load && !load_q;
        wr         = stop_ok && Load && (rise || !done_q);
        count_base = rise ? '0 : count_q;
        count_d    = wr ? count_base + 1'b1 : count_base;
        done_d     = (done_q && !rise) || (wr && count_d == DEPTH);
        fe_d       = (fe_q && !rise) || stop_bad;
        wr_en_d    = wr;
        wr_addr_d  = wr ? count_base[ADDR_W-1:0] : wr_addr_q;
        wr_data_d  = wr ? shift_q : wr_data_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            load_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fe_q      <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            load_q    <= Load;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fe_q      <= fe_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign Wr_en      = wr_en_q;
    assign Wr_addr    = wr_addr_q;
    assign Wr_data    = wr_data_q;
    assign FE         = fe_q;
    assign Busy       = state_q != IDLE;
    assign Done       = done_q;
    assign Byte_count = count_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed bench for the UART program loader at 16 clocks per bit.
module tb_uart_program_loader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic Reset, RX, Load;
    logic Wr_en, FE, Busy, Done;
    logic [4:0] Wr_addr;
    logic [7:0] Wr_data;
    logic [5:0] Byte_count;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int base = 0;
    logic busy_mid = 1'b0;
    logic [4:0] log_a [0:63];
    logic [7:0] log_d [0:63];

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(5), .DATA_W(8), .MEM_DEPTH(32)) dut (
        .Clk(clk), .Reset(Reset), .RX(RX), .Load(Load),
        .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .FE(FE), .Busy(Busy), .Done(Done), .Byte_count(Byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Wr_en && wr_cnt < 64) begin
            log_a[wr_cnt] = Wr_addr;
            log_d[wr_cnt] = Wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(CPB);
            if (i == 4) busy_mid = Busy;
        end
        RX = stop;
        tick(CPB);
        RX = 1'b1;
    endtask

    task automatic toggle_load();
        Load = 1'b0;
        tick(3);
        Load = 1'b1;
        tick(3);
    endtask

    initial begin
        Reset = 1'b0;
        RX = 1'b1;
        Load = 1'b0;
        tick(3);
        chk("rst_wr_en", 32'(Wr_en), 0);
        chk("rst_addr", 32'(Wr_addr), 0);
        chk("rst_data", 32'(Wr_data), 0);
        chk("rst_fe", 32'(FE), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_count", 32'(Byte_count), 0);
        Reset = 1'b1;
        Load = 1'b1;
        tick(5);

        base = wr_cnt;
        send(8'hA5, 1'b1);
        tick(20);
        chk("a5_busy_mid", 32'(busy_mid), 1);
        chk("a5_writes", 32'(wr_cnt - base), 1);
        chk("a5_addr", 32'(log_a[base]), 0);
        chk("a5_data", 32'(log_d[base]), 32'hA5);
        chk("a5_count", 32'(Byte_count), 1);
        chk("a5_fe", 32'(FE), 0);
        chk("a5_busy_end", 32'(Busy), 0);

        toggle_load();
        chk("tog1_count", 32'(Byte_count), 0);
        base = wr_cnt;
        send(8'h3F, 1'b1);
        send(8'h81, 1'b1);
        send(8'hFF, 1'b1);
        tick(20);
        chk("b2b_writes", 32'(wr_cnt - base), 3);
        chk("b2b_addr0", 32'(log_a[base]), 0);
        chk("b2b_data0", 32'(log_d[base]), 32'h3F);
        chk("b2b_addr1", 32'(log_a[base+1]), 1);
        chk("b2b_data1", 32'(log_d[base+1]), 32'h81);
        chk("b2b_addr2", 32'(log_a[base+2]), 2);
        chk("b2b_data2", 32'(log_d[base+2]), 32'hFF);
        chk("b2b_count", 32'(Byte_count), 3);

        toggle_load();
        base = wr_cnt;
        send(8'h55, 1'b0);
        tick(20);
        chk("fe_set", 32'(FE), 1);
        chk("fe_nowrite", 32'(wr_cnt - base), 0);
        chk("fe_count", 32'(Byte_count), 0);
        send(8'h12, 1'b1);
        tick(20);
        chk("fe_sticky", 32'(FE), 1);
        chk("fe_writes", 32'(wr_cnt - base), 1);
        chk("fe_addr", 32'(log_a[base]), 0);
        chk("fe_data", 32'(log_d[base]), 32'h12);
        toggle_load();
        chk("fe_clear", 32'(FE), 0);
        chk("fe_count_clr", 32'(Byte_count), 0);

        base = wr_cnt;
        RX = 1'b0;
        tick(5);
        chk("glitch_busy", 32'(Busy), 1);
        RX = 1'b1;
        tick(30);
        chk("glitch_idle", 32'(Busy), 0);
        chk("glitch_nowrite", 32'(wr_cnt - base), 0);
        chk("glitch_fe", 32'(FE), 0);

        base = wr_cnt;
        for (int i = 0; i < 33; i++) send(8'(i), 1'b1);
        tick(20);
        chk("full_writes", 32'(wr_cnt - base), 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("full_addr%0d", i), 32'(log_a[base+i]), 32'(i));
            chk($sformatf("full_data%0d", i), 32'(log_d[base+i]), 32'(i));
        end
        chk("full_done", 32'(Done), 1);
        chk("full_count", 32'(Byte_count), 32);
        chk("full_hold_addr", 32'(Wr_addr), 31);
        chk("full_hold_data", 32'(Wr_data), 32'h1F);
        toggle_load();
        chk("full_done_clr", 32'(Done), 0);
        chk("full_count_clr", 32'(Byte_count), 0);

        Load = 1'b0;
        base = wr_cnt;
        send(8'h77, 1'b1);
        tick(20);
        chk("noload_writes", 32'(wr_cnt - base), 0);
        chk("noload_count", 32'(Byte_count), 0);

        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            RX = ((8'h9C >> i) & 8'h01) != 0;
            tick(CPB);
        end
        RX = 1'b1;
        tick(8);
        chk("mid_busy", 32'(Busy), 1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(Wr_en), 0);
        chk("mid_rst_addr", 32'(Wr_addr), 0);
        chk("mid_rst_data", 32'(Wr_data), 0);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_count", 32'(Byte_count), 0);
        tick(3);
        Reset = 1'b1;
        Load = 1'b1;
        tick(200);
        chk("post_rst_writes", 32'(wr_cnt - base), 0);
        chk("post_rst_busy", 32'(Busy), 0);
        chk("post_rst_fe", 32'(FE), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- UART receive front end plus program loader. Sits directly upstream of the CPU instruction memory.
- While Load is high, it deserialises 8N1 bytes arriving on RX and writes them to sequential instruction-memory addresses starting at 0.
- Reports framing errors, progress (byte count) and completion (memory full) to the CPU top level.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 5, instruction-memory address width.
- DATA_W, 8, instruction width; equals UART data bits.
- MEM_DEPTH, 32, number of words to load before Done.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, idle high, asynchronous to Clk.
- Load  input  1  level; high = program-load mode.
- Wr_en  output  1  one-cycle instruction-memory write strobe.
- Wr_addr  output  ADDR_W  write address.
- Wr_data  output  DATA_W  write data.
- FE  output  1  sticky framing error.
- Busy  output  1  receiver is mid-frame.
- Done  output  1  MEM_DEPTH words written.
- Byte_count  output  ADDR_W+1  words written in the current load session (0..MEM_DEPTH).

Behaviour:
- Reset (Reset=0, asynchronous):
  - Wr_en=0, Wr_addr=0, Wr_data=0, FE=0, Busy=0, Done=0, Byte_count=0.
  - FSM goes to IDLE; RX synchroniser flops are forced to 1.
  - Reset mid-frame aborts the frame; nothing is written.
- RX passes through a 2-flop synchroniser. All FSM sampling uses the synchronised value (2-cycle input latency).
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronised RX=0 -> START with bit timer cleared. Busy=0 only in IDLE.
  - START: at timer = CLKS_PER_BIT/2-1 (mid start bit), sample RX.
    - RX=1: false start -> IDLE, no error flagged.
    - RX=0: -> DATA with timer cleared and bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample RX.
    - RX=1: byte is valid.
    - RX=0: FE<=1 and the byte is discarded.
    - Either way -> IDLE in the same cycle. The next start edge may be accepted from the following cycle.
- Write rule: the cycle after a valid stop sample, if Load=1 and Done=0:
  - Wr_en=1 for exactly one cycle, Wr_addr=pointer, Wr_data=received byte.
  - Pointer and Byte_count increment on that cycle.
  - Wr_addr/Wr_data hold their values until the next write.
- Load is evaluated at write time only. A byte whose stop bit completes while Load=0 is received and dropped (no Wr_en, no count change). A Load falling edge mid-frame therefore drops that byte.
- Load rising edge (registered, detected on the cycle Load goes 0->1):
  - pointer=0, Byte_count=0, Done=0, FE=0.
  - Receiver FSM is not reset; an in-flight frame continues.
  - If the rising edge and a write coincide, clear takes priority and that byte is written to address 0, leaving Byte_count=1.
- Done:
  - Set on the cycle Byte_count becomes MEM_DEPTH.
  - Further valid bytes produce no Wr_en.
  - Pointer does not wrap.
  - Done cleared only by Load rising edge or reset.
- FE:
  - Sticky; the pointer is not advanced by an erroneous byte.
  - Cleared only by Load rising edge or reset.
  - Reception continues normally after an error.
- Byte_count width is ADDR_W+1 so that MEM_DEPTH is representable. Pointer width is ADDR_W and equals Byte_count[ADDR_W-1:0].

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Reset low then high, Load=1, send 0xA5 -> single Wr_en pulse with Wr_addr=0, Wr_data=0xA5; Byte_count=1, FE=0, Busy high during frame then 0.
- Send 0x3F, 0x81, 0xFF back-to-back (no idle bits) -> three Wr_en pulses at addresses 0, 1, 2 with matching data; Byte_count=3.
- Send 0x55 with stop bit forced 0, then good 0x12 -> FE=1 and no write for 0x55; 0x12 written at Wr_addr=0; FE stays 1. Toggle Load 0->1 -> FE=0, Byte_count=0.
- RX low glitch for 5 cycles then high -> FSM returns to IDLE, Busy drops, no Wr_en, FE=0.
- Send 33 bytes 0x00..0x20 with Load=1 -> 32 writes at addresses 0..31, Done=1 after the 32nd write, byte 0x20 gives no Wr_en, Byte_count=32. Load 0->1 -> Done=0, Byte_count=0.
- Load=0, send 0x77 -> no Wr_en. Separately, drive Reset low during bit 4 of 0x9C -> all outputs 0 immediately; release with RX idle -> no write, Busy=0.
